cv32e40p_rf_recovery_ctrl: RTL
==============================

// Module: cv32e40p_rf_recovery_ctrl
// PURPOSE
//  Sequences rollback of a cv32e40p after a detected fault (lockstep/ECC mismatch).
//  On request it holds the core in setback, then replays a checkpointed register file
//  into the core through its two recovery write ports (2 regs/cycle), then releases it.
//  Sits beside cv32e40p_wrapper; drives its setback_i, recover_i, regfile_*_{a,b}_i.
// PARAMETERS
//  SETBACK_CYCLES  4   cycles setback_o is held high before replay; legal range >= 1
//  CNT_W           16  width of saturating recovery event counter
// PORTS
//  clk_i             in   1     clock
//  rst_i             in   1     reset, asynchronous, active-high
//  recovery_req_i    in   1     level request; sampled only in IDLE
//  setback_o         out  1     to core setback_i
//  recover_o         out  1     to core recover_i
//  backup_re_o       out  1     checkpoint RF read enable
//  backup_raddr_a_o  out  6     checkpoint read addr, even reg of pair
//  backup_raddr_b_o  out  6     checkpoint read addr, odd reg of pair
//  backup_rdata_a_i  in   32    read data for raddr_a, valid 1 cycle after backup_re_o
//  backup_rdata_b_i  in   32    read data for raddr_b, valid 1 cycle after backup_re_o
//  regfile_waddr_a_o out  6     core RF write port A addr
//  regfile_wdata_a_o out  32    core RF write port A data
//  regfile_we_a_o    out  1     core RF write port A enable
//  regfile_waddr_b_o out  6     core RF write port B addr
//  regfile_wdata_b_o out  32    core RF write port B data
//  regfile_we_b_o    out  1     core RF write port B enable
//  busy_o            out  1     high in any state but IDLE
//  done_o            out  1     1-cycle pulse when recovery completes
//  recovery_cnt_o    out  CNT_W completed recoveries, saturating
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0; async assert clears mid-sequence.
//  FSM IDLE -> SETBACK -> REPLAY -> DRAIN -> DONE -> IDLE.
//  IDLE: recovery_req_i=1 at edge -> SETBACK; else stay.
//  SETBACK: setback_o=1, recover_o=1 for exactly SETBACK_CYCLES cycles -> REPLAY.
//  REPLAY: recover_o=1; cycle k (k=0..NPAIR-1) backup_re_o=1, raddr_a=2k, raddr_b=2k+1;
//   after pair NPAIR-1 -> DRAIN. NPAIR=16 (x0..x31), 32 with FP option.
//  Write pipeline: registered; read issued cycle k -> waddr/wdata/we on cycle k+1
//   (wdata = backup_rdata_*_i captured at edge). we_a suppressed for addr 0 (x0).
//  DRAIN: last pair write visible, recover_o=1 -> DONE.
//  DONE: done_o=1, recover_o=0, setback_o=0, recovery_cnt_o += 1 (saturate at all-ones)
//   -> IDLE. Req still high in IDLE starts a new sequence next edge.
//  Requests in non-IDLE states ignored (no queueing).
//  Latency req edge -> first RF write: SETBACK_CYCLES+2 cycles; total busy:
//   SETBACK_CYCLES+NPAIR+2 cycles.
//  backup_raddr_* and regfile_* outputs are 0 whenever corresponding enable is 0.
// CONFIGURATION
//  CV32E40P_RF_RECOVERY_FP_EN defined: NPAIR=32, replays regs 0..63 (FP regs 32..63,
//   f0 at 32 is written). Undefined: NPAIR=16, address bit 5 always 0, regs 0..31 only.
// STRUCTURE
//  Package cv32e40p_rf_recovery_pkg: rec_state_e enum (IDLE,SETBACK,REPLAY,DRAIN,DONE),
//   NPAIR_INT=16, NPAIR_FP=32, RF_ADDR_W=6.
//  Single module, no sub-module: FSM, setback down-counter, pair counter,
//   one write-pipeline register stage, event counter.
// TESTING
//  Reset mid-REPLAY (k=5): all outputs 0 same cycle, busy_o=0, next req restarts at pair 0.
//  Req pulse, SETBACK_CYCLES=4, backup reg i = 0xA5A5_0000+i: setback_o high 4 cycles,
//   writes pairs (0,1)..(30,31) with matching data, we_a low for addr 0, done_o 1 pulse.
//  Req held high 2 sequences: recovery_cnt_o 0->1->2; second SETBACK starts 1 cycle after DONE.
//  Req toggled during REPLAY: no restart, write sequence unchanged, cnt increments once.
//  FP_EN defined: 32 replay cycles, addr 32 written (we_a=1), last pair (62,63); busy 38 cycles.
//  CNT_W=2, 4 recoveries: recovery_cnt_o saturates at 3.

Source files
------------

// File: rtl/cv32e40p_rf_recovery_pkg.sv
// Shared types and constants for the cv32e40p register-file recovery controller.
// Provides the sequencer state enum, pair counts and the RF address width.
package cv32e40p_rf_recovery_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETBACK,
        REPLAY,
        DRAIN,
        DONE
    } rec_state_e;

    localparam int unsigned NPAIR_INT = 16;
    localparam int unsigned NPAIR_FP  = 32;
    localparam int unsigned RF_ADDR_W = 6;

endpackage

// File: rtl/cv32e40p_rf_recovery_ctrl.sv
// Rolls a cv32e40p back after a fault: setback, replay checkpointed RF pairwise, release.
// Ports: clk_i/rst_i (async high), recovery_req_i, setback_o/recover_o to core,
//   backup_re_o/backup_raddr_{a,b}_o/backup_rdata_{a,b}_i to checkpoint RF,
//   regfile_{waddr,wdata,we}_{a,b}_o to core RF, busy_o, done_o, recovery_cnt_o.
// Define CV32E40P_RF_RECOVERY_FP_EN to also replay the FP registers (addresses 32..63).
module cv32e40p_rf_recovery_ctrl
    import cv32e40p_rf_recovery_pkg::*;
#(
    parameter int unsigned SETBACK_CYCLES = 4,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 recovery_req_i,
    output logic                 setback_o,
    output logic                 recover_o,
    output logic                 backup_re_o,
    output logic [RF_ADDR_W-1:0] backup_raddr_a_o,
    output logic [RF_ADDR_W-1:0] backup_raddr_b_o,
    input  logic [31:0]          backup_rdata_a_i,
    input  logic [31:0]          backup_rdata_b_i,
    output logic [RF_ADDR_W-1:0] regfile_waddr_a_o,
    output logic [31:0]          regfile_wdata_a_o,
    output logic                 regfile_we_a_o,
    output logic [RF_ADDR_W-1:0] regfile_waddr_b_o,
    output logic [31:0]          regfile_wdata_b_o,
    output logic                 regfile_we_b_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     recovery_cnt_o
);

`ifdef CV32E40P_RF_RECOVERY_FP_EN
    localparam int unsigned NPAIR = NPAIR_FP;
`else
    localparam int unsigned NPAIR = NPAIR_INT;
`endif
    localparam int unsigned PAIR_W = $clog2(NPAIR);
    localparam int unsigned SB_W   = (SETBACK_CYCLES > 1) ? $clog2(SETBACK_CYCLES) : 1;
    localparam logic [SB_W-1:0]   SB_LOAD   = SB_W'(SETBACK_CYCLES - 1);
    localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(NPAIR - 1);

    rec_state_e             state_q, state_d;
    logic [SB_W-1:0]        sb_cnt_q;
    logic [PAIR_W-1:0]      pair_q;
    logic [CNT_W-1:0]       evt_cnt_q;
    logic                   rd_en;
    logic [RF_ADDR_W-1:0]   raddr_a, raddr_b;
    logic                   we_a_q, we_b_q;
    logic [RF_ADDR_W-1:0]   waddr_a_q, waddr_b_q;

    always_comb begin
        state_d   = state_q;
        setback_o = 1'b0;
        recover_o = 1'b0;
        rd_en     = 1'b0;
        busy_o    = 1'b1;
        done_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (recovery_req_i) state_d = SETBACK;
            end
            SETBACK: begin
                setback_o = 1'b1;
                recover_o = 1'b1;
                if (sb_cnt_q == '0) state_d = REPLAY;
            end
            REPLAY: begin
                recover_o = 1'b1;
                rd_en     = 1'b1;
                if (pair_q == PAIR_LAST) state_d = DRAIN;
            end
            DRAIN: begin
                recover_o = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pair k reads registers 2k and 2k+1; addresses are forced to 0 outside REPLAY.
    assign raddr_a = rd_en ? RF_ADDR_W'({pair_q, 1'b0}) : '0;
    assign raddr_b = rd_en ? RF_ADDR_W'({pair_q, 1'b1}) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sb_cnt_q  <= '0;
            pair_q    <= '0;
            evt_cnt_q <= '0;
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
            waddr_a_q <= '0;
            waddr_b_q <= '0;
        end else begin
            state_q <= state_d;
            // Reload while idle so SETBACK always counts a full window.
            if (state_q == IDLE) begin
                sb_cnt_q <= SB_LOAD;
            end else if (state_q == SETBACK && sb_cnt_q != '0) begin
                sb_cnt_q <= sb_cnt_q - 1'b1;
            end
            if (state_q == REPLAY) begin
                pair_q <= pair_q + 1'b1;
            end else begin
                pair_q <= '0;
            end
            // Count on the way into DONE so the new value is visible with done_o.
            if (state_q == DRAIN && evt_cnt_q != '1) begin
                evt_cnt_q <= evt_cnt_q + 1'b1;
            end
            // x0 is hardwired in the core; never write it.
            we_a_q    <= rd_en && (raddr_a != '0);
            we_b_q    <= rd_en;
            waddr_a_q <= raddr_a;
            waddr_b_q <= raddr_b;
        end
    end

    // Checkpoint RF is synchronous: data for the read of cycle k arrives in cycle k+1,
    // which is exactly when the registered write address/enable for pair k are out.
    assign backup_re_o       = rd_en;
    assign backup_raddr_a_o  = raddr_a;
    assign backup_raddr_b_o  = raddr_b;
    assign regfile_we_a_o    = we_a_q;
    assign regfile_we_b_o    = we_b_q;
    assign regfile_waddr_a_o = we_a_q ? waddr_a_q : '0;
    assign regfile_waddr_b_o = we_b_q ? waddr_b_q : '0;
    assign regfile_wdata_a_o = we_a_q ? backup_rdata_a_i : '0;
    assign regfile_wdata_b_o = we_b_q ? backup_rdata_b_i : '0;
    assign recovery_cnt_o    = evt_cnt_q;

endmodule
